data_ram_resp: RTL

Data-memory responder at the far end of the MEM stage's load/store port. Accepts one word-aligned access request at a time from the MEM stage. Waits a programmable number of cycles, then performs a byte-masked write or full-word read on a local synchronous RAM and returns a single-cycle response. It drives a stall request back to the pipeline controller while an access is outstanding, so the pipeline holds until load data or store completion arrives.

---
 rtl/data_ram_resp_pkg.sv | 30 +++
 rtl/data_ram_resp_array.sv | 35 +++
 rtl/data_ram_resp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared types, state encoding and byte-merge helper for the data-memory responder.
package data_ram_resp_pkg;

  localparam int DATA_W    = 32;
  localparam int SEL_W     = 4;
  localparam int LAT_CNT_W = 4;

  typedef logic [DATA_W-1:0]    data_bus_t;
  typedef logic [SEL_W-1:0]     sel_bus_t;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_RESP = 2'd2
  } resp_state_e;

  // Overlay the enabled bytes of new_word onto old_word.
  function automatic data_bus_t byte_merge(input data_bus_t old_word,
                                           input data_bus_t new_word,
                                           input sel_bus_t  sel);
    data_bus_t res;
    res = old_word;
    for (int k = 0; k < SEL_W; k++) begin
      if (sel[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_ram_resp_array.sv
// Word-organised RAM with per-byte write enables and a registered, write-first read.
module data_ram_array
  import data_ram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  sel_bus_t         sel,
  input  logic [IDX_W-1:0] widx,
  input  logic [IDX_W-1:0] ridx,
  input  data_bus_t        wdata,
  output data_bus_t        rdata
);

  data_bus_t mem [DEPTH_WORDS];

  // Separate write/read indices let a zero-latency load issue its read on the
  // same edge that retires the preceding store; a same-word hit forwards the
  // merged word so read-after-write returns the new data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (sel[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) begin
      if (we && (widx == ridx)) rdata <= byte_merge(mem[ridx], wdata, sel);
      else                      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// MEM-stage data-memory responder: accepts one access, waits LATENCY cycles,
// then returns a single-cycle response while stalling the pipeline meanwhile.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        stallreq_o,
  output resp_state_e state_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam lat_cnt_t    LAT_INIT = (LATENCY == 0) ? '0 : lat_cnt_t'(LATENCY - 1);
  localparam bit          ZERO_LAT = (LATENCY == 0);

  // Handshake: a request is taken on a rising edge where req_i and ready_o are
  // both high; the MEM stage holds req_i and its fields until resp_valid_o.

  resp_state_e      state_q, state_d;
  lat_cnt_t         cnt_q, cnt_d;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  sel_bus_t         sel_q;
  data_bus_t        wdata_q;

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      unused_addr;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_ridx;
  data_bus_t        ram_rdata;
  logic             resp_now;

  assign req_idx     = addr_i[IDX_W+1:2];
  assign unused_addr = addr_i;
  assign ready_o     = (state_q == RESP_IDLE) || (state_q == RESP_RESP);
  assign accept      = req_i & ready_o;
  assign state_o     = state_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      idx_q   <= req_idx;
      sel_q   <= sel_i;
      wdata_q <= wdata_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESP_IDLE, RESP_RESP: begin
        if (accept) begin
          if (ZERO_LAT) begin
            state_d = RESP_RESP;
          end else begin
            state_d = RESP_WAIT;
            cnt_d   = LAT_INIT;
          end
        end else begin
          state_d = RESP_IDLE;
        end
      end
      RESP_WAIT: begin
        if (cnt_q == '0) state_d = RESP_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = RESP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output and RAM-control logic
  always_comb begin
    resp_now = (state_q == RESP_RESP);
    ram_we   = resp_now & we_q;
    ram_re   = 1'b0;
    ram_ridx = idx_q;
    // The read is launched on the edge that enters RESP so data is registered there.
    if (ZERO_LAT && accept) begin
      ram_re   = 1'b1;
      ram_ridx = req_idx;
    end else if ((state_q == RESP_WAIT) && (cnt_q == '0)) begin
      ram_re   = 1'b1;
      ram_ridx = idx_q;
    end
    resp_valid_o = resp_now;
    rdata_o      = (resp_now && !we_q) ? ram_rdata : '0;
    stallreq_o   = req_i & ~resp_now;
  end

  data_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .sel  (sel_q),
    .widx (idx_q),
    .ridx (ram_ridx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule
